draw_card_grid: RTL and testbench

DRAW_CARD_GRID -- requirements
Module: draw_card_grid

---
 rtl/draw_card_grid.sv | 190 +++++++++++++++++++
 tb/tb_draw_card_grid.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_card_grid.sv
// Overlays a 4x4 grid of 160x160 px memory-game cards with a blinking cursor border onto the video stream.
// Latency: 2 pclk cycles for every output (stage 1 decode, stage 2 colour select); timing signals are pure delays.
// Backpressure: none; one pixel is accepted and produced every pclk.
module draw_card_grid (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [31:0] card_state,
  input  logic [3:0]  cursor,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Grid geometry in pixels
  localparam int X0    = 144;
  localparam int Y0    = 16;
  localparam int PITCH = 192;
  localparam int SIZE  = 160;
  localparam int BW    = 4;
  localparam logic [10:0] H_VIS = 11'd1024;
  localparam logic [10:0] V_VIS = 11'd768;

  localparam logic [11:0] COL_CURSOR   = 12'hF00;
  localparam logic [11:0] COL_HIDDEN   = 12'h04A;
  localparam logic [11:0] COL_REVEALED = 12'hFC0;
  localparam logic [11:0] COL_MATCHED  = 12'h0A0;

  // Decode one axis with plain compares: {hit, near_edge, index[1:0]}
  function automatic logic [3:0] axis_decode(input logic [10:0] pos, input int origin);
    logic [3:0]  res;
    logic [10:0] lo;
    logic [10:0] hi;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      lo = 11'(origin + c * PITCH);
      hi = 11'(origin + c * PITCH + SIZE);
      if (pos >= lo && pos < hi) begin
        res = {1'b1, (pos < lo + 11'(BW)) || (pos >= hi - 11'(BW)), 2'(c)};
      end
    end
    return res;
  endfunction

  // Frame-synchronous state
  logic        vsync_prev;
  logic        frame_start;
  logic [31:0] card_state_sh;
  logic [3:0]  cursor_sh;
  logic [4:0]  frame_cnt;
  logic        blink_on;

  // Stage 0 combinational decode
  logic [3:0] hdec;
  logic [3:0] vdec;
  logic       visible_c;
  logic       inside_c;
  logic       border_c;
  logic [3:0] idx_c;

  // Stage 1 registers
  logic [10:0] hcount_s1;
  logic [10:0] vcount_s1;
  logic        hsync_s1;
  logic        vsync_s1;
  logic        hblnk_s1;
  logic        vblnk_s1;
  logic [11:0] rgb_s1;
  logic        inside_s1;
  logic        border_s1;
  logic [3:0]  idx_s1;

  // Stage 2 combinational colour select
  logic [4:0]  bit_pos;
  logic [1:0]  state_s1;
  logic [11:0] rgb_nxt;

  assign frame_start = vsync_in && !vsync_prev;

  // Card/border decode; counts outside the visible area never land inside a card
  always_comb begin
    hdec      = axis_decode(hcount_in, X0);
    vdec      = axis_decode(vcount_in, Y0);
    visible_c = (hcount_in < H_VIS) && (vcount_in < V_VIS);
    inside_c  = hdec[3] && vdec[3] && visible_c;
    border_c  = hdec[2] || vdec[2];
    idx_c     = {vdec[1:0], hdec[1:0]};
  end

  // Shadow capture and blink counter, updated only on the vsync rising edge
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_prev    <= 1'b0;
      card_state_sh <= '0;
      cursor_sh     <= '0;
      frame_cnt     <= '0;
      blink_on      <= 1'b1;
    end else begin
      vsync_prev <= vsync_in;
      if (frame_start) begin
        card_state_sh <= card_state;
        cursor_sh     <= cursor;
        if (frame_cnt == 5'd29) begin
          frame_cnt <= '0;
          blink_on  <= !blink_on;
        end else begin
          frame_cnt <= frame_cnt + 5'd1;
        end
      end
    end
  end

  // Stage 1: register decode results alongside the timing signals and background pixel
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_s1 <= '0;
      vcount_s1 <= '0;
      hsync_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      hblnk_s1  <= 1'b0;
      vblnk_s1  <= 1'b0;
      rgb_s1    <= '0;
      inside_s1 <= 1'b0;
      border_s1 <= 1'b0;
      idx_s1    <= '0;
    end else begin
      hcount_s1 <= hcount_in;
      vcount_s1 <= vcount_in;
      hsync_s1  <= hsync_in;
      vsync_s1  <= vsync_in;
      hblnk_s1  <= hblnk_in;
      vblnk_s1  <= vblnk_in;
      rgb_s1    <= rgb_in;
      inside_s1 <= inside_c;
      border_s1 <= border_c;
      idx_s1    <= idx_c;
    end
  end

  // Colour priority: blanking, then cursor border, then card state, else background
  always_comb begin
    bit_pos  = {idx_s1, 1'b0};
    state_s1 = card_state_sh[bit_pos +: 2];
    rgb_nxt  = rgb_s1;
    if (hblnk_s1 || vblnk_s1) begin
      rgb_nxt = 12'h000;
    end else if (inside_s1 && (idx_s1 == cursor_sh) && border_s1 && blink_on) begin
      rgb_nxt = COL_CURSOR;
    end else if (inside_s1) begin
      case (state_s1)
        2'b01:   rgb_nxt = COL_HIDDEN;
        2'b10:   rgb_nxt = COL_REVEALED;
        2'b11:   rgb_nxt = COL_MATCHED;
        default: rgb_nxt = rgb_s1;
      endcase
    end
  end

  // Stage 2: output registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_s1;
      vcount_out <= vcount_s1;
      hsync_out  <= hsync_s1;
      vsync_out  <= vsync_s1;
      hblnk_out  <= hblnk_s1;
      vblnk_out  <= vblnk_s1;
      rgb_out    <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_draw_card_grid.sv
// Directed bench for draw_card_grid: hand-computed expected pixels per scenario.
// Inputs change and outputs are sampled 1 ns after each rising pclk edge.
// Each scenario task does its own comparisons and steps the shared counters.
module tb_draw_card_grid;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [31:0] card_state;
  logic [3:0]  cursor;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  int n_cmp = 0;
  int n_bad = 0;

  draw_card_grid dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .card_state(card_state), .cursor(cursor),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Hold one pixel for two edges so it reaches the output
  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] c);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = c;
    step();
    step();
  endtask

  task automatic frame_start();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    hcount_in = 11'd500; vcount_in = 11'd300; rgb_in = 12'hFFF;
    hsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1; vsync_in = 1'b0;
    do_reset();
    n_cmp++;
    if ({hcount_out, vcount_out} !== 22'd0) begin
      n_bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hcount_out, vcount_out);
    end
    n_cmp++;
    if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {hsync_out, vsync_out, hblnk_out, vblnk_out});
    end
    n_cmp++;
    if (rgb_out !== 12'h000) begin
      n_bad++; $display("FAIL reset_rgb: got %h want 000", rgb_out);
    end
    n_cmp++;
    if (dut.frame_cnt !== 5'd0 || dut.blink_on !== 1'b1) begin
      n_bad++; $display("FAIL reset_blink: got cnt=%0d blink=%b want cnt=0 blink=1", dut.frame_cnt, dut.blink_on);
    end
    hcount_in = '0; vcount_in = '0; rgb_in = '0;
    hsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    do_reset();
  endtask

  task automatic test_latency();
    hcount_in = 11'd100; vcount_in = 11'd100; rgb_in = 12'h123; hsync_in = 1'b1;
    step();
    n_cmp++;
    if (hcount_out !== 11'd0 || rgb_out !== 12'h000 || hsync_out !== 1'b0) begin
      n_bad++; $display("FAIL latency_1cyc: got h=%0d rgb=%h hs=%b want h=0 rgb=000 hs=0", hcount_out, rgb_out, hsync_out);
    end
    step();
    n_cmp++;
    if (hcount_out !== 11'd100 || vcount_out !== 11'd100 || hsync_out !== 1'b1) begin
      n_bad++; $display("FAIL latency_timing: got h=%0d v=%0d hs=%b want 100/100/1", hcount_out, vcount_out, hsync_out);
    end
    n_cmp++;
    if (rgb_out !== 12'h123) begin
      n_bad++; $display("FAIL latency_rgb: got %h want 123", rgb_out);
    end
    hsync_in = 1'b0;
  endtask

  task automatic test_card_decode();
    logic [10:0] hs [7] = '{11'd144, 11'd304, 11'd879, 11'd880, 11'd143, 11'd303, 11'd144};
    logic [10:0] vs [7] = '{11'd16,  11'd16,  11'd751, 11'd751, 11'd16,  11'd175, 11'd15};
    // cursor=15 with blink on paints the card-15 border red at (879,751)
    logic [11:0] ex [7] = '{12'h04A, 12'h5A5, 12'hF00, 12'h5A5, 12'h5A5, 12'h04A, 12'h5A5};
    do_reset();
    card_state = 32'h5555_5555;
    cursor = 4'd15;
    frame_start();
    for (int i = 0; i < 7; i++) begin
      pix(hs[i], vs[i], 12'h5A5);
      n_cmp++;
      if (rgb_out !== ex[i]) begin
        n_bad++; $display("FAIL decode(%0d,%0d): got %h want %h", hs[i], vs[i], rgb_out, ex[i]);
      end
    end
    // 30th frame start turns blink off, leaving the plain hidden colour
    for (int i = 0; i < 29; i++) frame_start();
    pix(11'd879, 11'd751, 12'h5A5);
    n_cmp++;
    if (rgb_out !== 12'h04A) begin
      n_bad++; $display("FAIL decode_corner_noblink: got %h want 04A", rgb_out);
    end
  endtask

  task automatic test_states();
    logic [10:0] hs [3] = '{11'd340, 11'd530, 11'd150};
    logic [10:0] vs [3] = '{11'd300, 11'd300, 11'd20};
    logic [11:0] ex [3] = '{12'hFC0, 12'h0A0, 12'h6B6};
    card_state = 32'h0000_3800;
    cursor = 4'd15;
    frame_start();
    for (int i = 0; i < 3; i++) begin
      pix(hs[i], vs[i], 12'h6B6);
      n_cmp++;
      if (rgb_out !== ex[i]) begin
        n_bad++; $display("FAIL states(%0d,%0d): got %h want %h", hs[i], vs[i], rgb_out, ex[i]);
      end
    end
  endtask

  task automatic test_cursor_blink();
    logic [11:0] ex_border [4] = '{12'hF00, 12'hF00, 12'h04A, 12'hF00};
    int          extra     [4] = '{0, 28, 1, 30};
    do_reset();
    card_state = 32'h0000_0001;
    cursor = 4'd0;
    frame_start();
    // checkpoints after 1, 29, 30 and 60 frame starts
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < extra[k]; i++) frame_start();
      pix(11'd145, 11'd100, 12'h111);
      n_cmp++;
      if (rgb_out !== ex_border[k]) begin
        n_bad++; $display("FAIL blink_border_%0d: got %h want %h", k, rgb_out, ex_border[k]);
      end
      pix(11'd200, 11'd100, 12'h111);
      n_cmp++;
      if (rgb_out !== 12'h04A) begin
        n_bad++; $display("FAIL blink_interior_%0d: got %h want 04A", k, rgb_out);
      end
    end
  endtask

  task automatic test_shadowing();
    card_state = 32'h0000_0002;
    for (int i = 0; i < 2; i++) begin
      pix(11'd200, 11'd100, 12'h777);
      n_cmp++;
      if (rgb_out !== 12'h04A) begin
        n_bad++; $display("FAIL shadow_midframe_%0d: got %h want 04A", i, rgb_out);
      end
    end
    vsync_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    vsync_in = 1'b0;
    step();
    pix(11'd200, 11'd100, 12'h777);
    n_cmp++;
    if (rgb_out !== 12'hFC0) begin
      n_bad++; $display("FAIL shadow_after_vsync: got %h want FC0", rgb_out);
    end
    n_cmp++;
    if (dut.frame_cnt !== 5'd1) begin
      n_bad++; $display("FAIL shadow_single_count: got %0d want 1", dut.frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    // card 0 revealed, cursor 0 with blink on: x 300..303 is the right border
    logic [11:0] ex [8] = '{12'hFC0, 12'hFC0, 12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'h106, 12'h107};
    vcount_in = 11'd100;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        hcount_in = 11'(298 + i);
        rgb_in    = 12'(12'h100 + i);
      end
      step();
      if (i >= 1) begin
        n_cmp++;
        if (rgb_out !== ex[i-1] || hcount_out !== 11'(298 + i - 1)) begin
          n_bad++; $display("FAIL b2b_%0d: got h=%0d rgb=%h want h=%0d rgb=%h", i - 1, hcount_out, rgb_out, 298 + i - 1, ex[i-1]);
        end
      end
    end
  endtask

  task automatic test_blank_reset();
    hblnk_in = 1'b1;
    pix(11'd1030, 11'd100, 12'hFFF);
    n_cmp++;
    if (rgb_out !== 12'h000 || hblnk_out !== 1'b1) begin
      n_bad++; $display("FAIL hblank: got rgb=%h hb=%b want 000/1", rgb_out, hblnk_out);
    end
    hblnk_in = 1'b0;
    vblnk_in = 1'b1;
    pix(11'd200, 11'd100, 12'hFFF);
    n_cmp++;
    if (rgb_out !== 12'h000) begin
      n_bad++; $display("FAIL vblank: got %h want 000", rgb_out);
    end
    vblnk_in = 1'b0;
    // counter is at 1; 29 more starts wrap it and turn blink off
    for (int i = 0; i < 29; i++) frame_start();
    n_cmp++;
    if (dut.blink_on !== 1'b0 || dut.frame_cnt !== 5'd0) begin
      n_bad++; $display("FAIL blink_pre_reset: got blink=%b cnt=%0d want 0/0", dut.blink_on, dut.frame_cnt);
    end
    hsync_in = 1'b1;
    pix(11'd300, 11'd100, 12'hABC);
    step();
    rst = 1'b1;
    step();
    n_cmp++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== 38'd0) begin
      n_bad++; $display("FAIL midline_reset_outputs: got h=%0d v=%0d hs=%b rgb=%h want all 0", hcount_out, vcount_out, hsync_out, rgb_out);
    end
    n_cmp++;
    if (dut.frame_cnt !== 5'd0 || dut.blink_on !== 1'b1) begin
      n_bad++; $display("FAIL midline_reset_blink: got cnt=%0d blink=%b want 0/1", dut.frame_cnt, dut.blink_on);
    end
    rst = 1'b0;
    hsync_in = 1'b0;
    pix(11'd200, 11'd100, 12'h3C3);
    n_cmp++;
    if (rgb_out !== 12'h3C3) begin
      n_bad++; $display("FAIL post_reset_passthru: got %h want 3C3", rgb_out);
    end
    frame_start();
    pix(11'd200, 11'd100, 12'h3C3);
    n_cmp++;
    if (rgb_out !== 12'hFC0) begin
      n_bad++; $display("FAIL post_reset_reload: got %h want FC0", rgb_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0; rgb_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    card_state = '0; cursor = '0;
    test_reset();
    test_latency();
    test_card_decode();
    test_states();
    test_cursor_blink();
    test_shadowing();
    test_back_to_back();
    test_blank_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
